// File: rtl/mips_pkg.sv
// Shared writeback types: default datapath widths, the hard-wired zero register,
// and the {rd, data} result record carried through the writeback stage.
package mips_pkg;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam logic [ADDR_W-1:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic [ADDR_W-1:0] rd;
    logic [DATA_W-1:0] data;
  } wb_req_t;
endpackage

// File: rtl/wb_arbiter_if.sv
// Writeback bundle: ALU/mul-div result inputs and the two register-file write ports.
// The master side produces results; the slave side is the arbiter.
interface wb_arbiter_if
  import mips_pkg::*;
#(
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic              alu0_valid;
  logic [ADDR_W-1:0] alu0_rd;
  logic [DATA_W-1:0] alu0_data;
  logic              alu1_valid;
  logic [ADDR_W-1:0] alu1_rd;
  logic [DATA_W-1:0] alu1_data;
  logic              md_valid;
  logic              md_ready;
  logic [ADDR_W-1:0] md_rd;
  logic [DATA_W-1:0] md_data;
  logic              write1;
  logic [ADDR_W-1:0] wr1;
  logic [DATA_W-1:0] wd1;
  logic              write2;
  logic [ADDR_W-1:0] wr2;
  logic [DATA_W-1:0] wd2;
  logic [CW-1:0]     md_count;

  modport master (
    output alu0_valid, alu0_rd, alu0_data,
    output alu1_valid, alu1_rd, alu1_data,
    output md_valid, md_rd, md_data,
    input  md_ready,
    input  write1, wr1, wd1, write2, wr2, wd2, md_count
  );

  modport slave (
    input  alu0_valid, alu0_rd, alu0_data,
    input  alu1_valid, alu1_rd, alu1_data,
    input  md_valid, md_rd, md_data,
    output md_ready,
    output write1, wr1, wd1, write2, wr2, wd2, md_count
  );
endinterface

// File: rtl/wb_fifo.sv
// Mul/div result queue: one push and up to two pops per cycle, with the two
// oldest entries visible so the arbiter can drain both in one cycle.
module wb_fifo
  import mips_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic          clk_i,
  input  logic          reset_i,
  input  logic          push_i,
  input  wb_req_t       push_data_i,
  input  logic [1:0]    pop_i,
  output wb_req_t       head_o,
  output wb_req_t       head1_o,
  output logic [CW-1:0] count_o
);
  wb_req_t       mem_q [DEPTH];
  logic [PW-1:0] rd_ptr_q;
  logic [PW-1:0] wr_ptr_q;
  logic [CW-1:0] count_q;

  // Storage carries no reset; occupancy alone decides which entries are live.
  always_ff @(posedge clk_i) begin
    if (push_i) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_q + PW'(push_i);
      rd_ptr_q <= rd_ptr_q + PW'(pop_i);
      count_q  <= count_q + CW'(push_i) - CW'(pop_i);
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign head1_o = mem_q[rd_ptr_q + PW'(1)];
  assign count_o = count_q;
endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: ALU pipes own their port slots; mul/div results fill any
// free slot oldest-first from the queue, falling back to a same-cycle bypass.
module wb_arbiter
  import mips_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  wb_arbiter_if.slave bus
);
  localparam int CW = $clog2(DEPTH) + 1;

  wb_req_t       head;
  wb_req_t       head1;
  wb_req_t       in_req;
  logic [CW-1:0] count;
  logic          md_ready;
  logic          slot1_busy;
  logic          slot2_busy;
  logic          in_cand;
  logic          bypass;
  logic          push;
  logic [1:0]    nfree;
  logic [1:0]    avail;
  logic [1:0]    pops;
  wb_req_t       item0;
  wb_req_t       item1;
  logic          item0_v;
  logic          item1_v;
  logic          write1_d, write1_q;
  logic          write2_d, write2_q;
  wb_req_t       p1_d, p1_q;
  wb_req_t       p2_d, p2_q;

  assign md_ready   = !reset && (count < CW'(DEPTH));
  assign in_req     = '{rd: bus.md_rd, data: bus.md_data};
  assign in_cand    = bus.md_valid && md_ready && (bus.md_rd != REG_ZERO);
  assign slot1_busy = bus.alu0_valid && (bus.alu0_rd != REG_ZERO);
  assign slot2_busy = bus.alu1_valid && (bus.alu1_rd != REG_ZERO);

  // The bypass only lands once every queued entry ahead of it has a slot.
  always_comb begin
    nfree  = {1'b0, !slot1_busy} + {1'b0, !slot2_busy};
    avail  = (count >= CW'(2)) ? 2'd2 : count[1:0];
    pops   = (avail < nfree) ? avail : nfree;
    bypass = in_cand && (pops < nfree);
    push   = in_cand && !bypass;
    if (pops != 2'd0) begin
      item0 = head;
    end else begin
      item0 = in_req;
    end
    if (pops == 2'd2) begin
      item1 = head1;
    end else begin
      item1 = in_req;
    end
    item0_v = (pops != 2'd0) || bypass;
    item1_v = (pops == 2'd2) || ((pops == 2'd1) && bypass);
  end

  // Slot1 takes the oldest mul/div candidate when free, slot2 the next one.
  always_comb begin
    write1_d = 1'b0;
    write2_d = 1'b0;
    p1_d     = '0;
    p2_d     = '0;
    if (slot1_busy) begin
      write1_d = 1'b1;
      p1_d     = '{rd: bus.alu0_rd, data: bus.alu0_data};
      if (slot2_busy) begin
        write2_d = 1'b1;
        p2_d     = '{rd: bus.alu1_rd, data: bus.alu1_data};
      end else begin
        write2_d = item0_v;
        p2_d     = item0_v ? item0 : '0;
      end
    end else begin
      write1_d = item0_v;
      p1_d     = item0_v ? item0 : '0;
      if (slot2_busy) begin
        write2_d = 1'b1;
        p2_d     = '{rd: bus.alu1_rd, data: bus.alu1_data};
      end else begin
        write2_d = item1_v;
        p2_d     = item1_v ? item1 : '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      write1_q <= 1'b0;
      write2_q <= 1'b0;
      p1_q     <= '0;
      p2_q     <= '0;
    end else begin
      write1_q <= write1_d;
      write2_q <= write2_d;
      p1_q     <= p1_d;
      p2_q     <= p2_d;
    end
  end

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk_i      (clk),
    .reset_i    (reset),
    .push_i     (push),
    .push_data_i(in_req),
    .pop_i      (pops),
    .head_o     (head),
    .head1_o    (head1),
    .count_o    (count)
  );

  assign bus.md_ready = md_ready;
  assign bus.write1   = write1_q;
  assign bus.wr1      = p1_q.rd;
  assign bus.wd1      = p1_q.data;
  assign bus.write2   = write2_q;
  assign bus.wr2      = p2_q.rd;
  assign bus.wd2      = p2_q.data;
  assign bus.md_count = count;
endmodule
